alu_cmd_issuer: RTL

Initiator-side controller for the 4-bit `alu` datapath. It accepts operation requests on a valid/ready stream and drives registered operands and opcode to the ALU. It captures the 8-bit result one cycle later and returns it with the request tag on a valid/ready response stream. Divide-by-zero is flagged on the response, and optional per-opcode statistics counters support functional-coverage closure.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_op_stats.sv | 82 ++++++++
 rtl/alu_cmd_issuer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command issuer.
// Optional statistics counters are enabled with the ALU_STATS_EN macro.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } issuer_state_e;

    localparam logic [7:0] DIV0_RESULT = 8'hFF;

endpackage

// File: rtl/alu_op_stats.sv
// Saturating per-opcode and divide-by-zero counters for the ALU command issuer.
// Instantiated by alu_cmd_issuer only when ALU_STATS_EN is defined.
module alu_op_stats
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             accept_i,
    input  alu_op_e          op_i,
    input  logic             div0_i,
    output logic [CNT_W-1:0] cnt_add_o,
    output logic [CNT_W-1:0] cnt_sub_o,
    output logic [CNT_W-1:0] cnt_mul_o,
    output logic [CNT_W-1:0] cnt_div_o,
    output logic [CNT_W-1:0] cnt_err_o
);

    logic [CNT_W-1:0] add_q, add_d;
    logic [CNT_W-1:0] sub_q, sub_d;
    logic [CNT_W-1:0] mul_q, mul_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] err_q, err_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    // Next-state: bump the counter selected by the accepted opcode
    always_comb begin
        add_d = add_q;
        sub_d = sub_q;
        mul_d = mul_q;
        div_d = div_q;
        err_d = err_q;
        if (accept_i) begin
            case (op_i)
                OP_ADD:  add_d = sat_inc(add_q);
                OP_SUB:  sub_d = sat_inc(sub_q);
                OP_MUL:  mul_d = sat_inc(mul_q);
                OP_DIV:  div_d = sat_inc(div_q);
                default: add_d = add_q;
            endcase
        end else begin
            add_d = add_q;
        end
        if (div0_i) begin
            err_d = sat_inc(err_q);
        end else begin
            err_d = err_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            add_q <= '0;
            sub_q <= '0;
            mul_q <= '0;
            div_q <= '0;
            err_q <= '0;
        end else begin
            add_q <= add_d;
            sub_q <= sub_d;
            mul_q <= mul_d;
            div_q <= div_d;
            err_q <= err_d;
        end
    end

    assign cnt_add_o = add_q;
    assign cnt_sub_o = sub_q;
    assign cnt_mul_o = mul_q;
    assign cnt_div_o = div_q;
    assign cnt_err_o = err_q;

endmodule

// File: rtl/alu_cmd_issuer.sv
// Request/response controller driving registered operands into an external 4-bit ALU.
// Define ALU_STATS_EN to add the per-opcode statistics counter ports.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int TAG_W = 4
`ifdef ALU_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_a,
    input  logic [3:0]       req_b,
    input  logic [1:0]       req_op,
    input  logic [TAG_W-1:0] req_tag,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [1:0]       alu_op,
    input  logic [7:0]       alu_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_y,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err
`ifdef ALU_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt_add,
    output logic [CNT_W-1:0] cnt_sub,
    output logic [CNT_W-1:0] cnt_mul,
    output logic [CNT_W-1:0] cnt_div,
    output logic [CNT_W-1:0] cnt_err
`endif
);

    issuer_state_e    state_q, state_d;
    logic [3:0]       alu_a_q, alu_a_d;
    logic [3:0]       alu_b_q, alu_b_d;
    alu_op_e          alu_op_q, alu_op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [7:0]       rsp_y_q, rsp_y_d;
    logic             rsp_err_q, rsp_err_d;

    logic             accept_s;
    logic             div0_s;

    assign accept_s = (state_q == IDLE) && req_valid;
    // Only meaningful during EXEC, when alu_* carry the in-flight operation
    assign div0_s   = (alu_op_q == OP_DIV) && (alu_b_q == 4'd0);

    // Next-state and datapath-load logic
    always_comb begin
        state_d   = state_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        tag_d     = tag_q;
        rsp_y_d   = rsp_y_q;
        rsp_err_d = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    alu_a_d  = req_a;
                    alu_b_d  = req_b;
                    alu_op_d = alu_op_e'(req_op);
                    tag_d    = req_tag;
                    state_d  = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (div0_s) begin
                    rsp_y_d   = DIV0_RESULT;
                    rsp_err_d = 1'b1;
                end else begin
                    rsp_y_d   = alu_y;
                    rsp_err_d = 1'b0;
                end
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            alu_a_q   <= 4'd0;
            alu_b_q   <= 4'd0;
            alu_op_q  <= OP_ADD;
            tag_q     <= '0;
            rsp_y_q   <= 8'd0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            tag_q     <= tag_d;
            rsp_y_q   <= rsp_y_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_tag   = tag_q;
    assign rsp_err   = rsp_err_q;

`ifdef ALU_STATS_EN
    alu_op_stats #(
        .CNT_W(CNT_W)
    ) u_stats (
        .clk_i    (clk),
        .rst_i    (rst),
        .accept_i (accept_s),
        .op_i     (alu_op_e'(req_op)),
        .div0_i   ((state_q == EXEC) && div0_s),
        .cnt_add_o(cnt_add),
        .cnt_sub_o(cnt_sub),
        .cnt_mul_o(cnt_mul),
        .cnt_div_o(cnt_div),
        .cnt_err_o(cnt_err)
    );
`endif

endmodule
